// File: rtl/dm_capture_shift_update.sv
// Capture/shift/update data register for the debug module.
// A serial shift register loaded in parallel by capture and scanned through
// tdi/tdo. A bit counter guards the shadow register: an update commits only
// after a full-width scan and otherwise raises update_err.
module dm_capture_shift_update #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter bit                LSB_FIRST = 1'b1,
  parameter int unsigned       CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             shift,
  input  logic             update,
  input  logic [WIDTH-1:0] cap_val,
  input  logic             tdi,
  output logic             tdo,
  output logic [WIDTH-1:0] shift_q,
  output logic [WIDTH-1:0] shadow_q,
  output logic [CW-1:0]    bit_cnt,
  output logic             full,
  output logic             update_valid,
  output logic             update_err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] shadow_d;
  logic [CW-1:0]    bit_cnt_d, bit_cnt_q;
  logic             full_d, full_q;
  logic             update_valid_d, update_valid_q;
  logic             update_err_d, update_err_q;

  // Serial output is the bit that leaves on the next shift.
  assign tdo = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];

  assign bit_cnt      = bit_cnt_q;
  assign full         = full_q;
  assign update_valid = update_valid_q;
  assign update_err   = update_err_q;

  // Next state: capture beats shift; update sees pre-edge register and count.
  always_comb begin
    shift_d        = shift_q;
    shadow_d       = shadow_q;
    bit_cnt_d      = bit_cnt_q;
    update_valid_d = 1'b0;
    update_err_d   = 1'b0;

    if (capture) begin
      shift_d   = cap_val;
      bit_cnt_d = '0;
    end else if (shift) begin
      if (LSB_FIRST) begin
        shift_d = {tdi, shift_q[WIDTH-1:1]};
      end else begin
        shift_d = {shift_q[WIDTH-2:0], tdi};
      end
      if (bit_cnt_q != CNT_MAX) begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end

    if (update) begin
      if (full_q) begin
        shadow_d       = shift_q;
        update_valid_d = 1'b1;
      end else begin
        update_err_d   = 1'b1;
      end
    end

    full_d = (bit_cnt_d == CNT_MAX);
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q        <= RESET_VAL;
      shadow_q       <= RESET_VAL;
      bit_cnt_q      <= '0;
      full_q         <= 1'b0;
      update_valid_q <= 1'b0;
      update_err_q   <= 1'b0;
    end else begin
      shift_q        <= shift_d;
      shadow_q       <= shadow_d;
      bit_cnt_q      <= bit_cnt_d;
      full_q         <= full_d;
      update_valid_q <= update_valid_d;
      update_err_q   <= update_err_d;
    end
  end

endmodule

// File: tb/tb_dm_capture_shift_update.sv
// Testbench for dm_capture_shift_update: an LSB-first instance driven from a
// vector table through an expected-value queue, and an MSB-first instance
// exercised by a hand-written scan sequence.
module tb_dm_capture_shift_update;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  typedef struct {
    logic          rst;
    logic          cap;
    logic          sh;
    logic          upd;
    logic [W-1:0]  cv;
    logic          tdi;
    logic          chk_tdo;
    logic          e_tdo;
    logic [W-1:0]  e_sr;
    logic [W-1:0]  e_shadow;
    logic [CW-1:0] e_cnt;
    logic          e_full;
    logic          e_uv;
    logic          e_ue;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LSB-first instance
  logic          a_reset = 1'b1, a_capture = 1'b0, a_shift = 1'b0, a_update = 1'b0;
  logic [W-1:0]  a_cap_val = '0;
  logic          a_tdi = 1'b0;
  logic          a_tdo, a_full, a_uv, a_ue;
  logic [W-1:0]  a_sr, a_shadow;
  logic [CW-1:0] a_cnt;

  // MSB-first instance
  logic          b_reset = 1'b1, b_capture = 1'b0, b_shift = 1'b0, b_update = 1'b0;
  logic [W-1:0]  b_cap_val = '0;
  logic          b_tdi = 1'b0;
  logic          b_tdo, b_full, b_uv, b_ue;
  logic [W-1:0]  b_sr, b_shadow;
  logic [CW-1:0] b_cnt;

  dm_capture_shift_update #(.WIDTH(W), .RESET_VAL(8'h00), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(a_reset), .capture(a_capture), .shift(a_shift), .update(a_update),
    .cap_val(a_cap_val), .tdi(a_tdi), .tdo(a_tdo), .shift_q(a_sr), .shadow_q(a_shadow),
    .bit_cnt(a_cnt), .full(a_full), .update_valid(a_uv), .update_err(a_ue)
  );

  dm_capture_shift_update #(.WIDTH(W), .RESET_VAL(8'h00), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(b_reset), .capture(b_capture), .shift(b_shift), .update(b_update),
    .cap_val(b_cap_val), .tdi(b_tdi), .tdo(b_tdo), .shift_q(b_sr), .shadow_q(b_shadow),
    .bit_cnt(b_cnt), .full(b_full), .update_valid(b_uv), .update_err(b_ue)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic cap, input logic sh, input logic upd,
                     input logic [W-1:0] cv, input logic tdi, input logic ct, input logic et,
                     input logic [W-1:0] esr, input logic [W-1:0] esh, input logic [CW-1:0] ecnt,
                     input logic efull, input logic euv, input logic eue);
    vec_t v;
    v.rst = rst; v.cap = cap; v.sh = sh; v.upd = upd; v.cv = cv; v.tdi = tdi;
    v.chk_tdo = ct; v.e_tdo = et; v.e_sr = esr; v.e_shadow = esh; v.e_cnt = ecnt;
    v.e_full = efull; v.e_uv = euv; v.e_ue = eue;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    vec_t e;
    logic [W-1:0] msb_tdo_pat;

    // rst cap sh upd cv tdi | chk tdo | sr shadow cnt full uv ue (after the edge)
    add(1,0,0,0,8'h00,0, 0,0, 8'h00,8'h00,0,0,0,0);  // reset
    add(0,0,0,0,8'h00,0, 1,0, 8'h00,8'h00,0,0,0,0);  // idle after reset
    add(0,1,0,0,8'hA5,0, 1,0, 8'hA5,8'h00,0,0,0,0);  // capture A5
    add(0,0,1,0,8'h00,1, 1,1, 8'hD2,8'h00,1,0,0,0);  // shift in C3, LSB first
    add(0,0,1,0,8'h00,1, 1,0, 8'hE9,8'h00,2,0,0,0);
    add(0,0,1,0,8'h00,0, 1,1, 8'h74,8'h00,3,0,0,0);
    add(0,0,1,0,8'h00,0, 1,0, 8'h3A,8'h00,4,0,0,0);
    add(0,0,1,0,8'h00,0, 1,0, 8'h1D,8'h00,5,0,0,0);
    add(0,0,1,0,8'h00,0, 1,1, 8'h0E,8'h00,6,0,0,0);
    add(0,0,1,0,8'h00,1, 1,0, 8'h87,8'h00,7,0,0,0);
    add(0,0,1,0,8'h00,1, 1,1, 8'hC3,8'h00,8,1,0,0);  // full
    add(0,0,1,1,8'h00,0, 1,1, 8'h61,8'hC3,8,1,1,0);  // update+shift: shadow gets pre-shift
    add(0,0,0,0,8'h00,0, 1,1, 8'h61,8'hC3,8,1,0,0);  // pulse is one cycle
    add(0,0,0,1,8'h00,0, 1,1, 8'h61,8'h61,8,1,1,0);  // count not cleared by update
    add(0,0,0,1,8'h00,0, 1,1, 8'h61,8'h61,8,1,1,0);  // re-commit pulses again
    add(0,0,1,0,8'h00,1, 1,1, 8'hB0,8'h61,8,1,0,0);  // saturation: data moves, count holds
    add(0,0,1,0,8'h00,1, 1,0, 8'hD8,8'h61,8,1,0,0);
    add(0,0,1,0,8'h00,0, 1,0, 8'h6C,8'h61,8,1,0,0);
    add(0,0,1,0,8'h00,0, 1,0, 8'h36,8'h61,8,1,0,0);
    add(0,1,0,0,8'h3C,0, 1,0, 8'h3C,8'h61,0,0,0,0);  // short scan
    add(0,0,1,0,8'h00,1, 1,0, 8'h9E,8'h61,1,0,0,0);
    add(0,0,1,0,8'h00,1, 1,0, 8'hCF,8'h61,2,0,0,0);
    add(0,0,1,0,8'h00,1, 1,1, 8'hE7,8'h61,3,0,0,0);
    add(0,0,1,0,8'h00,1, 1,1, 8'hF3,8'h61,4,0,0,0);
    add(0,0,1,0,8'h00,1, 1,1, 8'hF9,8'h61,5,0,0,0);
    add(0,0,0,1,8'h00,0, 1,1, 8'hF9,8'h61,5,0,0,1);  // rejected update
    add(0,0,0,0,8'h00,0, 1,1, 8'hF9,8'h61,5,0,0,0);
    add(0,1,1,0,8'h5A,1, 1,1, 8'h5A,8'h61,0,0,0,0);  // capture beats shift
    add(0,0,1,0,8'h00,0, 1,0, 8'h2D,8'h61,1,0,0,0);
    add(0,0,1,0,8'h00,0, 1,1, 8'h16,8'h61,2,0,0,0);
    add(0,0,1,0,8'h00,0, 1,0, 8'h0B,8'h61,3,0,0,0);
    add(1,0,1,1,8'h00,0, 1,1, 8'h00,8'h00,0,0,0,0);  // reset mid-scan beats update
    add(0,0,0,1,8'h00,0, 1,0, 8'h00,8'h00,0,0,0,1);  // update right after reset is short
    add(0,0,0,0,8'h00,0, 1,0, 8'h00,8'h00,0,0,0,0);

    // Table-driven run: expected post-edge state is queued as each vector is driven.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      a_reset = v.rst; a_capture = v.cap; a_shift = v.sh; a_update = v.upd;
      a_cap_val = v.cv; a_tdi = v.tdi;
      #1;
      if (v.chk_tdo) chk($sformatf("lsb[%0d].tdo", i), 32'(a_tdo), 32'(v.e_tdo));
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk($sformatf("lsb[%0d].queue_empty", i), 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("lsb[%0d].shift_q", i),  32'(a_sr),     32'(e.e_sr));
        chk($sformatf("lsb[%0d].shadow_q", i), 32'(a_shadow), 32'(e.e_shadow));
        chk($sformatf("lsb[%0d].bit_cnt", i),  32'(a_cnt),    32'(e.e_cnt));
        chk($sformatf("lsb[%0d].full", i),     32'(a_full),   32'(e.e_full));
        chk($sformatf("lsb[%0d].upd_valid", i),32'(a_uv),     32'(e.e_uv));
        chk($sformatf("lsb[%0d].upd_err", i),  32'(a_ue),     32'(e.e_ue));
      end
    end

    // MSB-first scan: capture 0x81, shift eight zeros.
    msb_tdo_pat = 8'b1000_0001;
    @(negedge clk);
    b_reset = 1'b1;
    @(posedge clk); #1;
    chk("msb.reset.shift_q", 32'(b_sr), 32'h0);
    chk("msb.reset.bit_cnt", 32'(b_cnt), 32'h0);
    @(negedge clk);
    b_reset = 1'b0; b_capture = 1'b1; b_cap_val = 8'h81;
    @(posedge clk); #1;
    chk("msb.capture.shift_q", 32'(b_sr), 32'h81);
    @(negedge clk);
    b_capture = 1'b0; b_shift = 1'b1; b_tdi = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("msb.tdo[%0d]", i), 32'(b_tdo), 32'(msb_tdo_pat[i]));
      @(posedge clk); #1;
      chk($sformatf("msb.shift_q[%0d]", i), 32'(b_sr), 32'(8'(8'h81 << (i + 1))));
      chk($sformatf("msb.bit_cnt[%0d]", i), 32'(b_cnt), 32'(i + 1));
      chk($sformatf("msb.full[%0d]", i), 32'(b_full), 32'(i == 7));
      @(negedge clk);
    end
    b_shift = 1'b0; b_update = 1'b1;
    @(posedge clk); #1;
    chk("msb.update.valid", 32'(b_uv), 32'h1);
    chk("msb.update.shadow", 32'(b_shadow), 32'h0);
    @(negedge clk);
    b_update = 1'b0;
    @(posedge clk); #1;
    chk("msb.update.valid_drop", 32'(b_uv), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_capture_shift_update.md
Name: dm_capture_shift_update

Overview:
- Parametrised capture/shift/update data register for the debug module, successor to the single enable-plus-synchronous-load flop.
- Adds three things: a serial shift path, a shadow (update) register, and a shifted-bit counter that rejects short scans.
- Sits between the debug transport (DTM-side serial stream) and DM-side parallel register fields, e.g. DMI request/response words.

Parameters:
- WIDTH, 32, data register width in bits; must be >= 2.
- RESET_VAL, 0 (WIDTH bits), reset value of the shift and shadow registers.
- LSB_FIRST, 1, 1 = shift right (bit 0 out first); 0 = shift left (MSB out first).
- CW, $clog2(WIDTH+1), counter width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- capture  input  1  parallel-load cap_val into the shift register.
- shift  input  1  shift one bit in from tdi.
- update  input  1  commit the shift register to the shadow register.
- cap_val  input  WIDTH  parallel capture value.
- tdi  input  1  serial data in.
- tdo  output  1  serial data out.
- shift_q  output  WIDTH  current shift-register contents.
- shadow_q  output  WIDTH  committed (shadow) value.
- bit_cnt  output  CW  bits shifted since the last capture; saturating.
- full  output  1  bit_cnt == WIDTH.
- update_valid  output  1  one-cycle pulse: shadow register was written.
- update_err  output  1  one-cycle pulse: update rejected because the scan was short.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - shift register = RESET_VAL, shadow = RESET_VAL.
  - bit_cnt = 0; full, update_valid and update_err = 0.
  - Reset asserted mid-scan aborts the scan; no partial update.
- Shift-register priority is capture > shift > hold:
  - capture: shift register <= cap_val; bit_cnt <= 0.
  - shift with no capture:
    - LSB_FIRST=1: sr <= {tdi, sr[WIDTH-1:1]}.
    - LSB_FIRST=0: sr <= {sr[WIDTH-2:0], tdi}.
    - bit_cnt increments and saturates at WIDTH; further shifts keep moving data but the count stays at WIDTH.
  - Capture and shift in the same cycle: capture wins; the shift is dropped and bit_cnt = 0.
- tdo is combinational: sr[0] when LSB_FIRST=1, sr[WIDTH-1] when LSB_FIRST=0. It reflects the current register, i.e. the value before this cycle's shift.
- Update (evaluated against pre-edge state):
  - If update=1 and full=1: shadow <= sr (pre-shift, pre-capture value); update_valid = 1 the next cycle.
  - If update=1 and full=0: shadow is held; update_err = 1 the next cycle.
  - update concurrent with shift or capture: the shadow receives the old sr. The concurrent shift/capture still takes effect on sr and bit_cnt.
  - update does not clear bit_cnt. Repeated updates without a capture re-commit the same data, each pulsing update_valid.
- update_valid and update_err are registered, mutually exclusive, and 0 in every cycle not following an update.
- Latency:
  - shift_q, bit_cnt and full change 1 cycle after the control edge.
  - shadow_q changes 1 cycle after update, in the same cycle update_valid rises.
- No combinational path from any input to shift_q, shadow_q or bit_cnt.
- No X propagation: every register has a reset value.

Test Plan:
- Reset: assert reset 1 cycle, RESET_VAL=0 -> shift_q=0, shadow_q=0, bit_cnt=0, full=0, tdo=0, no pulses.
- Full scan, LSB_FIRST=1, WIDTH=8:
  - Stimulus: capture cap_val=0xA5, then 8 shifts with tdi sequence 1,1,0,0,0,0,1,1 (0xC3 LSB first), then update.
  - Response: tdo emits 1,0,1,0,0,1,0,1; bit_cnt steps 0→8; full=1; shadow_q=0xC3 with update_valid high exactly one cycle.
- Short scan: capture, 5 shifts, update -> bit_cnt=5, update_err pulses once, shadow_q unchanged from its prior value, update_valid=0.
- Simultaneous events:
  - Capture+shift in one cycle -> sr=cap_val, bit_cnt=0.
  - After a full scan, update+shift in one cycle -> shadow gets the pre-shift sr, sr shifts, bit_cnt stays 8.
- Saturation and reset mid-scan:
  - 12 shifts after capture (WIDTH=8) -> bit_cnt holds 8, full stays 1, data keeps shifting.
  - Reset after 3 shifts -> sr=RESET_VAL, bit_cnt=0, shadow unchanged from RESET_VAL.
- MSB-first, LSB_FIRST=0, WIDTH=8: capture 0x81, shift tdi=0 ×8 -> tdo emits 1,0,0,0,0,0,0,1; final shift_q=0x00.
